pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, meaning the program address width in bits.
REQ-002 The block SHALL have parameter CYC_W, default 3, meaning the width of the per-instruction cycle counter.
REQ-003 The block SHALL have parameter END_ADDR, default 2**ADDR_W-1, meaning the last program address.
REQ-004 The block SHALL have parameter WRAP, default 1, where 1 means wrap to 0 after END_ADDR and 0 means halt after END_ADDR.
REQ-005 The block SHALL have port clk, input, 1 bit: the system clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port en, input, 1 bit: advance enable; low means stall.
REQ-008 The block SHALL have port op_cycles, input, CYC_W bits: cycle count of the instruction at address, supplied by the decoder.
REQ-009 The block SHALL have port address, output, ADDR_W bits: the current program address (registered).
REQ-010 The block SHALL have port phase, output, CYC_W bits: the cycle index within the current instruction (registered).
REQ-011 The block SHALL have port instr_done, output, 1 bit: a one-cycle pulse in the first cycle of each new instruction (registered).
REQ-012 The block SHALL have port halted, output, 1 bit: high while the block is in state HALTED (registered).

Function
REQ-013 Instruction length len SHALL be op_cycles, with 0 treated as 1; len SHALL be captured into an internal register when phase==0 and en==1, and held for the rest of the instruction.
REQ-014 The last-phase condition SHALL be phase==len-1, using the live op_cycles when phase==0 and the captured len otherwise.
REQ-015 In state RUN with en==1 and not at the last phase, phase SHALL increment by 1 and address SHALL hold.
REQ-016 In state RUN with en==1 at the last phase, phase SHALL go to 0, the next address SHALL be selected per REQ-017 to REQ-019, and instr_done SHALL be 1 in the following cycle.
REQ-017 The next address SHALL be address+1 modulo 2**ADDR_W when address != END_ADDR.
REQ-018 When address==END_ADDR and WRAP==1, the next address SHALL be 0.
REQ-019 When address==END_ADDR and WRAP==0, address SHALL hold, the state SHALL become HALTED, and instr_done SHALL still pulse once.
REQ-020 With en==0, address, phase and the captured len SHALL hold, and instr_done SHALL be 0; a stall SHALL never drop or repeat a phase.
REQ-021 The states SHALL be RUN and HALTED. In HALTED, address and phase SHALL hold, phase SHALL be 0, and en is ignored; only reset exits HALTED.
REQ-022 instr_done SHALL be 0 in every cycle not specified by REQ-016.
REQ-023 A single-cycle instruction (len 1) SHALL advance the address every enabled cycle, with instr_done high continuously.

Reset
REQ-024 When rst==0 at a rising clk edge, the next state SHALL be: address=0, phase=0, captured len=1, instr_done=0, halted=0, state=RUN.
REQ-025 Reset SHALL take priority over en, branch load and halt, including in the middle of an instruction.

Configuration
REQ-026 With macro PC_SEQ_BRANCH_EN defined, the block SHALL have inputs ld_en (1 bit) and ld_addr (ADDR_W bits). If ld_en==1 at the last phase with en==1, the next address SHALL be ld_addr, overriding REQ-017 to REQ-019, and no halt occurs. ld_en is ignored at any other time.
REQ-027 Without PC_SEQ_BRANCH_EN, the ld_en and ld_addr ports SHALL NOT exist and the address SHALL follow only REQ-017 to REQ-019.

Verification
REQ-028 Reset, then en=1, op_cycles=3 held -> address steps 0,1,2 every 3 cycles; phase sequence is 0,1,2,0; instr_done pulses at cycles 3 and 6.
REQ-029 op_cycles changes from 3 to 2 in the second cycle of an instruction -> that instruction still lasts 3 cycles; the next instruction lasts 2 cycles.
REQ-030 ADDR_W=2, WRAP=0, op_cycles=1 -> address 0,1,2,3; halted=1 from the cycle after address 3 completes; address stays 3; en toggling has no effect.
REQ-031 WRAP=1, END_ADDR=5 -> address goes 5 then 0; en=0 for 4 cycles at phase 1 -> phase stays 1 and instr_done stays 0.
REQ-032 rst=0 at phase 2 of address 7 -> next cycle address=0, phase=0, halted=0; op_cycles=0 -> address advances every cycle.
REQ-033 With PC_SEQ_BRANCH_EN defined: ld_en=1, ld_addr=9 at the last phase of address 4 -> next address is 9; ld_en=1 at a non-last phase -> ignored.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: steps through multi-cycle instructions, wrapping or halting at END_ADDR.
// Optional branch load (ld_en/ld_addr) is enabled by defining PC_SEQ_BRANCH_EN.
module pc_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int CYC_W    = 3,
  parameter int END_ADDR = 2**ADDR_W-1,
  parameter int WRAP     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CYC_W-1:0]  op_cycles,
`ifdef PC_SEQ_BRANCH_EN
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
`endif
  output logic [ADDR_W-1:0] address,
  output logic [CYC_W-1:0]  phase,
  output logic              instr_done,
  output logic              halted
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] END_A = ADDR_W'(END_ADDR);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [CYC_W-1:0]    phase_q, phase_d;
  logic [CYC_W-1:0]    len_q, len_d;
  logic                instr_done_q, instr_done_d;
  logic [CYC_W-1:0]    op_len;
  logic                last_phase;

  always_comb begin
    op_len       = (op_cycles == '0) ? CYC_W'(1) : op_cycles;
    // In phase 0 the length has not been captured yet, so decide from the live opcode length.
    last_phase   = (phase_q == '0) ? (op_len == CYC_W'(1))
                                   : (phase_q == len_q - CYC_W'(1));
    state_d      = state_q;
    address_d    = address_q;
    phase_d      = phase_q;
    len_d        = len_q;
    instr_done_d = 1'b0;
    if (state_q == RUN && en) begin
      if (phase_q == '0) len_d = op_len;
      if (last_phase) begin
        phase_d      = '0;
        instr_done_d = 1'b1;
`ifdef PC_SEQ_BRANCH_EN
        if (ld_en) begin
          address_d = ld_addr;
        end else
`endif
        if (address_q != END_A) begin
          address_d = address_q + ADDR_W'(1);
        end else if (WRAP != 0) begin
          address_d = '0;
        end else begin
          state_d = HALTED;
        end
      end else begin
        phase_d = phase_q + CYC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RUN;
      address_q    <= '0;
      phase_q      <= '0;
      len_q        <= CYC_W'(1);
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      phase_q      <= phase_d;
      len_q        <= len_d;
      instr_done_q <= instr_done_d;
    end
  end

  assign address    = address_q;
  assign phase      = phase_q;
  assign instr_done = instr_done_q;
  assign halted     = (state_q == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: three instances (default, 2-bit halting, END_ADDR=5 wrapping) share stimulus;
// each directed vector carries the hand-computed outputs expected after the edge that consumes it.
module tb_pc_sequencer;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [2:0] op_cycles = 3'd0;
`ifdef PC_SEQ_BRANCH_EN
  logic       ld_en = 1'b0;
  logic [4:0] ld_addr = 5'd0;
  logic       ld_nxt = 1'b0;
  logic [4:0] la_nxt = 5'd0;
`endif

  logic [4:0] a_addr; logic [2:0] a_ph; logic a_done, a_halt;
  logic [1:0] b_addr; logic [2:0] b_ph; logic b_done, b_halt;
  logic [4:0] c_addr; logic [2:0] c_ph; logic c_done, c_halt;

  pc_sequencer u_a (
    .clk(clk), .rst(rst), .en(en), .op_cycles(op_cycles),
`ifdef PC_SEQ_BRANCH_EN
    .ld_en(ld_en), .ld_addr(ld_addr),
`endif
    .address(a_addr), .phase(a_ph), .instr_done(a_done), .halted(a_halt)
  );

  pc_sequencer #(.ADDR_W(2), .CYC_W(3), .WRAP(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .op_cycles(op_cycles),
`ifdef PC_SEQ_BRANCH_EN
    .ld_en(ld_en), .ld_addr(ld_addr[1:0]),
`endif
    .address(b_addr), .phase(b_ph), .instr_done(b_done), .halted(b_halt)
  );

  pc_sequencer #(.ADDR_W(5), .CYC_W(3), .END_ADDR(5), .WRAP(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .op_cycles(op_cycles),
`ifdef PC_SEQ_BRANCH_EN
    .ld_en(ld_en), .ld_addr(ld_addr),
`endif
    .address(c_addr), .phase(c_ph), .instr_done(c_done), .halted(c_halt)
  );

  // scoreboard: {sel[1:0], addr[4:0], phase[2:0], done, halted, idx[7:0]}
  localparam int EXP_W = 20;
  logic [EXP_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int vec_idx = 0;
  logic [1:0] sel = 2'd0;

  // driver: inputs change on the falling edge and are consumed by the next rising edge
  task automatic step(input logic r, input logic e, input logic [2:0] op,
                      input logic [4:0] ea, input logic [2:0] ep,
                      input logic ed, input logic eh);
    @(negedge clk);
    rst = r;
    en = e;
    op_cycles = op;
`ifdef PC_SEQ_BRANCH_EN
    ld_en = ld_nxt;
    ld_addr = la_nxt;
`endif
    exp_q.push_back({sel, ea, ep, ed, eh, 8'(vec_idx)});
    vec_idx++;
  endtask

  // monitor: one popped expectation per rising edge, sampled just after it
  logic [EXP_W-1:0] m_ent;
  logic [9:0] m_got, m_want;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      m_ent = exp_q.pop_front();
      m_want = m_ent[17:8];
      case (m_ent[19:18])
        2'd0:    m_got = {a_addr, a_ph, a_done, a_halt};
        2'd1:    m_got = {3'b000, b_addr, b_ph, b_done, b_halt};
        default: m_got = {c_addr, c_ph, c_done, c_halt};
      endcase
      n_vec++;
      if (m_got !== m_want) begin
        n_err++;
        $display("FAIL vec%0d dut%0d: got addr=%0d phase=%0d done=%b halted=%b, expected addr=%0d phase=%0d done=%b halted=%b",
                 m_ent[7:0], m_ent[19:18], m_got[9:5], m_got[4:2], m_got[1], m_got[0],
                 m_want[9:5], m_want[4:2], m_want[1], m_want[0]);
      end
    end
  end

  initial begin
    // default instance: 3-cycle instructions, phase 0,1,2 and pulses at cycles 3 and 6
    sel = 2'd0;
    step(0, 1, 3, 0, 0, 0, 0);
    step(1, 1, 3, 0, 1, 0, 0);
    step(1, 1, 3, 0, 2, 0, 0);
    step(1, 1, 3, 1, 0, 1, 0);
    step(1, 1, 3, 1, 1, 0, 0);
    step(1, 1, 3, 1, 2, 0, 0);
    step(1, 1, 3, 2, 0, 1, 0);
    // op_cycles drops to 2 mid-instruction: this one keeps 3 cycles, next one takes 2
    step(1, 1, 3, 2, 1, 0, 0);
    step(1, 1, 2, 2, 2, 0, 0);
    step(1, 1, 2, 3, 0, 1, 0);
    step(1, 1, 2, 3, 1, 0, 0);
    step(1, 1, 2, 4, 0, 1, 0);
    // stall at phase 1 for 4 cycles with a changing opcode; captured length must hold
    step(1, 1, 3, 4, 1, 0, 0);
    step(1, 0, 1, 4, 1, 0, 0);
    step(1, 0, 1, 4, 1, 0, 0);
    step(1, 0, 1, 4, 1, 0, 0);
    step(1, 0, 1, 4, 1, 0, 0);
    step(1, 1, 1, 4, 2, 0, 0);
    step(1, 1, 1, 5, 0, 1, 0);
    step(1, 0, 1, 5, 0, 0, 0);
    // single-cycle instructions, then reset at phase 2 of address 7
    step(1, 1, 1, 6, 0, 1, 0);
    step(1, 1, 1, 7, 0, 1, 0);
    step(1, 1, 3, 7, 1, 0, 0);
    step(1, 1, 3, 7, 2, 0, 0);
    step(0, 1, 3, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 1, 0);
    step(1, 1, 0, 2, 0, 1, 0);
    step(1, 1, 0, 3, 0, 1, 0);

    // 2-bit halting instance
    sel = 2'd1;
    step(0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 1, 0);
    step(1, 1, 1, 2, 0, 1, 0);
    step(1, 1, 1, 3, 0, 1, 0);
    step(1, 1, 1, 3, 0, 1, 1);
    step(1, 0, 1, 3, 0, 0, 1);
    step(1, 1, 1, 3, 0, 0, 1);
    step(1, 1, 3, 3, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 0);

    // END_ADDR=5 wrapping instance
    sel = 2'd2;
    step(0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 1, 0);
    step(1, 1, 1, 2, 0, 1, 0);
    step(1, 1, 1, 3, 0, 1, 0);
    step(1, 1, 1, 4, 0, 1, 0);
    step(1, 1, 1, 5, 0, 1, 0);
    step(1, 1, 1, 0, 0, 1, 0);
    step(1, 1, 1, 1, 0, 1, 0);

`ifdef PC_SEQ_BRANCH_EN
    // branch load: ignored at a non-last phase, taken at the last phase of address 4
    sel = 2'd0;
    step(0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 1, 0);
    step(1, 1, 1, 2, 0, 1, 0);
    step(1, 1, 1, 3, 0, 1, 0);
    step(1, 1, 1, 4, 0, 1, 0);
    ld_nxt = 1'b1;
    la_nxt = 5'd9;
    step(1, 1, 2, 4, 1, 0, 0);
    step(1, 1, 2, 9, 0, 1, 0);
    ld_nxt = 1'b0;
    step(1, 1, 2, 9, 1, 0, 0);
`endif

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
